// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the system-memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   // Who is waiting for read data in the cycle after a grant.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive cycles a requester was denied.
// at_max tells the arbiter to force priority to this requester.
module mem_arb_starve #(
   parameter int STARVE_MAX = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic req,
   input  logic gnt,
   output logic at_max
);

   localparam logic [7:0] MAX_V = 8'(STARVE_MAX);

   logic [7:0] starve_cnt;

   // Count denied cycles; any grant or a dropped request restarts the count.
   always_ff @(posedge CLK) begin
      if (RST)
         starve_cnt <= '0;
      else if (!req || gnt)
         starve_cnt <= '0;
      else if (starve_cnt != MAX_V)
         starve_cnt <= starve_cnt + 8'd1;
   end

   assign at_max = (starve_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// CPU / DMA arbiter in front of the single-port synchronous system memory.
// One access per cycle, combinational grant, one-cycle read latency with the
// read data steered back to whichever port issued the read.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   // CPU port
   input  logic              CPU_REQ,
   input  logic              CPU_WE,
   input  logic [ADDR_W-1:0] CPU_ADDR,
   input  logic [DATA_W-1:0] CPU_DIN,
   output logic              CPU_GNT,
   output logic              CPU_RVALID,
   output logic [DATA_W-1:0] CPU_DOUT,
   // DMA / loader port
   input  logic              DMA_REQ,
   input  logic              DMA_WE,
   input  logic [ADDR_W-1:0] DMA_ADDR,
   input  logic [DATA_W-1:0] DMA_DIN,
   output logic              DMA_GNT,
   output logic              DMA_RVALID,
   output logic [DATA_W-1:0] DMA_DOUT,
   // memory side
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_DIN,
   input  logic [DATA_W-1:0] MEM_DOUT
);

   logic              cpu_win;
   logic              dma_win;
   logic              dma_at_max;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_din;
   owner_e            rd_owner;
   owner_e            rd_owner_nxt;
   logic [DATA_W-1:0] cpu_hold;
   logic [DATA_W-1:0] dma_hold;
   logic              cpu_rv;
   logic              dma_rv;

   mem_arb_starve #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .CLK    (CLK),
      .RST    (RST),
      .req    (DMA_REQ),
      .gnt    (dma_win),
      .at_max (dma_at_max)
   );

   // Winner pick: starved DMA first, then CPU, then DMA; nothing under reset.
   always_comb begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
      if (!RST) begin
         if (DMA_REQ && dma_at_max)
            dma_win = 1'b1;
         else if (CPU_REQ)
            cpu_win = 1'b1;
         else if (DMA_REQ)
            dma_win = 1'b1;
      end
   end

   assign CPU_GNT = cpu_win;
   assign DMA_GNT = dma_win;

   // Memory-side mux; address/data park on the last granted values when idle.
   always_comb begin
      MEM_WE   = 1'b0;
      MEM_ADDR = last_addr;
      MEM_DIN  = last_din;
      if (RST) begin
         MEM_ADDR = '0;
         MEM_DIN  = '0;
      end else if (cpu_win) begin
         MEM_WE   = CPU_WE;
         MEM_ADDR = CPU_ADDR;
         MEM_DIN  = CPU_DIN;
      end else if (dma_win) begin
         MEM_WE   = DMA_WE;
         MEM_ADDR = DMA_ADDR;
         MEM_DIN  = DMA_DIN;
      end
   end

   // Remember the last driven address/data so an idle bus does not toggle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_addr <= '0;
         last_din  <= '0;
      end else if (cpu_win || dma_win) begin
         last_addr <= MEM_ADDR;
         last_din  <= MEM_DIN;
      end
   end

   // Next read owner: only a read grant leaves data in flight.
   always_comb begin
      rd_owner_nxt = OWN_NONE;
      if (!RST) begin
         if (cpu_win && !CPU_WE)
            rd_owner_nxt = OWN_CPU;
         else if (dma_win && !DMA_WE)
            rd_owner_nxt = OWN_DMA;
      end
   end

   // Read tag register, one entry deep since read latency is one cycle.
   always_ff @(posedge CLK) begin
      if (RST)
         rd_owner <= OWN_NONE;
      else
         rd_owner <= rd_owner_nxt;
   end

   // A reset landing on the return cycle drops the in-flight read.
   assign cpu_rv = !RST && (rd_owner == OWN_CPU);
   assign dma_rv = !RST && (rd_owner == OWN_DMA);

   assign CPU_RVALID = cpu_rv;
   assign DMA_RVALID = dma_rv;

   // Per-port DOUT hold registers, loaded only by that port's own return.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cpu_hold <= '0;
         dma_hold <= '0;
      end else begin
         if (cpu_rv)
            cpu_hold <= MEM_DOUT;
         if (dma_rv)
            dma_hold <= MEM_DOUT;
      end
   end

   // Live memory data during the return cycle, held value otherwise.
   always_comb begin
      CPU_DOUT = cpu_hold;
      DMA_DOUT = dma_hold;
      if (RST) begin
         CPU_DOUT = '0;
         DMA_DOUT = '0;
      end else begin
         if (cpu_rv)
            CPU_DOUT = MEM_DOUT;
         if (dma_rv)
            DMA_DOUT = MEM_DOUT;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a cycle-level reference model.
module tb_mem_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 8;
   localparam int SMAX = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          CPU_REQ, CPU_WE, CPU_GNT, CPU_RVALID;
   logic [AW-1:0] CPU_ADDR;
   logic [DW-1:0] CPU_DIN, CPU_DOUT;
   logic          DMA_REQ, DMA_WE, DMA_GNT, DMA_RVALID;
   logic [AW-1:0] DMA_ADDR;
   logic [DW-1:0] DMA_DIN, DMA_DOUT;
   logic          MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_DIN;
   logic [DW-1:0] MEM_DOUT = '0;

   int n_chk  = 0;
   int n_fail = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .CLK(CLK), .RST(RST),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
      .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_DOUT(CPU_DOUT),
      .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_DIN(DMA_DIN),
      .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_DOUT(DMA_DOUT),
      .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
   );

   always #5 CLK = ~CLK;

   // Preload image: 0x0000=0xA2, 0x0001=0x07, the rest a fixed pattern.
   function automatic logic [7:0] init_val(input logic [15:0] a);
      if (a == 16'h0000) return 8'hA2;
      if (a == 16'h0001) return 8'h07;
      return 8'((int'(a) * 37 + 5) & 255);
   endfunction

   // System memory device: 64K x 8, synchronous read and write.
   logic [7:0] tb_mem [0:65535];
   bit         tb_wv  [0:65535];

   function automatic logic [7:0] tb_rd(input logic [15:0] a);
      return tb_wv[a] ? tb_mem[a] : init_val(a);
   endfunction

   always @(posedge CLK) begin
      if (MEM_WE) begin
         tb_mem[MEM_ADDR] <= MEM_DIN;
         tb_wv[MEM_ADDR]  <= 1'b1;
      end
      MEM_DOUT <= tb_rd(MEM_ADDR);
   end

   // Reference model state.
   logic [7:0]  ref_mem [0:65535];
   bit          ref_wv  [0:65535];
   int          m_cnt = 0;   // consecutive denied DMA cycles
   int          m_pend = 0;  // 0 none, 1 cpu, 2 dma
   logic [7:0]  m_pend_data = '0;
   logic [7:0]  m_hold_c = '0, m_hold_d = '0;
   logic [15:0] m_last_addr = '0;
   logic [7:0]  m_last_din = '0;
   bit          g_cpu, g_dma;    // model grants of the last cycle
   logic        d_cgnt, d_dgnt;  // DUT grants seen in the last cycle

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_wv[a] ? ref_mem[a] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance it.
   task automatic step();
      int         win;
      logic       ewe, rvc, rvd;
      logic [15:0] ea;
      logic [7:0] ed, dc, dd;
      @(negedge CLK);
      win = 0;
      if (!RST) begin
         if (DMA_REQ && m_cnt >= SMAX) win = 2;
         else if (CPU_REQ)             win = 1;
         else if (DMA_REQ)             win = 2;
      end
      ewe = (win == 1) ? CPU_WE : (win == 2) ? DMA_WE : 1'b0;
      ea  = RST ? 16'h0 : (win == 1) ? CPU_ADDR : (win == 2) ? DMA_ADDR : m_last_addr;
      ed  = RST ? 8'h0  : (win == 1) ? CPU_DIN  : (win == 2) ? DMA_DIN  : m_last_din;
      rvc = !RST && m_pend == 1;
      rvd = !RST && m_pend == 2;
      dc  = RST ? 8'h0 : rvc ? m_pend_data : m_hold_c;
      dd  = RST ? 8'h0 : rvd ? m_pend_data : m_hold_d;

      chk("cpu_gnt",    CPU_GNT,    32'(win == 1));
      chk("dma_gnt",    DMA_GNT,    32'(win == 2));
      chk("mem_we",     MEM_WE,     32'(ewe));
      chk("mem_addr",   MEM_ADDR,   32'(ea));
      chk("mem_din",    MEM_DIN,    32'(ed));
      chk("cpu_rvalid", CPU_RVALID, 32'(rvc));
      chk("dma_rvalid", DMA_RVALID, 32'(rvd));
      chk("cpu_dout",   CPU_DOUT,   32'(dc));
      chk("dma_dout",   DMA_DOUT,   32'(dd));
      d_cgnt = CPU_GNT;
      d_dgnt = DMA_GNT;

      if (RST) begin
         m_cnt = 0; m_pend = 0; m_hold_c = '0; m_hold_d = '0;
         m_last_addr = '0; m_last_din = '0;
      end else begin
         if (rvc) m_hold_c = m_pend_data;
         if (rvd) m_hold_d = m_pend_data;
         m_pend = 0;
         if (win != 0) begin
            m_last_addr = ea;
            m_last_din  = ed;
            if (ewe) begin
               ref_mem[ea] = ed;
               ref_wv[ea]  = 1'b1;
            end else begin
               m_pend      = win;
               m_pend_data = ref_rd(ea);
            end
         end
         if (!DMA_REQ || win == 2) m_cnt = 0;
         else if (m_cnt < SMAX)    m_cnt++;
      end
      g_cpu = (win == 1);
      g_dma = (win == 2);
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [15:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return 16'($urandom_range(0, 7));
   endfunction

   task automatic new_cpu();
      CPU_REQ  = ($urandom_range(0, 3) != 0);
      CPU_WE   = 1'($urandom_range(0, 1));
      CPU_ADDR = rand_addr();
      CPU_DIN  = 8'($urandom);
   endtask

   task automatic new_dma();
      DMA_REQ  = ($urandom_range(0, 2) != 0);
      DMA_WE   = 1'($urandom_range(0, 1));
      DMA_ADDR = rand_addr();
      DMA_DIN  = 8'($urandom);
   endtask

   initial begin
      int c;
      RST = 1'b1;
      CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 16'h0000; CPU_DIN = 8'hFF;
      DMA_REQ = 1'b0; DMA_WE = 1'b0; DMA_ADDR = '0;      DMA_DIN = '0;

      // Reset with a pending CPU write: nothing may reach memory.
      repeat (3) step();
      chk("rst_mem0", tb_rd(16'h0000), 8'hA2);

      // Release reset with a CPU read of 0x0000 pending.
      RST = 1'b0; CPU_WE = 1'b0;
      step();
      chk("first_gnt", d_cgnt, 1);
      CPU_REQ = 1'b0;
      DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_ADDR = 16'h0001;
      repeat (5) step();
      chk("cpu_dout_hold", CPU_DOUT, 8'hA2);

      // DMA write then CPU read-back.
      DMA_WE = 1'b1; DMA_ADDR = 16'h0200; DMA_DIN = 8'h55;
      step();
      DMA_REQ = 1'b0;
      CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 16'h0200;
      step();
      CPU_REQ = 1'b0;
      step();
      chk("cpu_rd_200", CPU_DOUT, 8'h55);

      // Starvation: CPU hogs the bus, DMA forced through on its 5th cycle.
      CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 16'h0003;
      DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_ADDR = 16'h0001;
      c = 0;
      while (c < 20) begin
         step();
         if (d_dgnt) break;
         c++;
      end
      chk("starve_cycle", c, 4);
      chk("starve_cpu_off", d_cgnt, 0);
      DMA_REQ = 1'b0;
      step();
      chk("post_starve_cpu", d_cgnt, 1);
      chk("dma_starve_data", DMA_DOUT, 8'h07);
      CPU_REQ = 1'b0;

      // Back-to-back reads from alternating ports.
      step();
      CPU_REQ = 1'b1; CPU_ADDR = 16'h0001;
      step();
      CPU_REQ = 1'b0;
      DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_ADDR = 16'h0000;
      step();
      DMA_REQ = 1'b0;
      step();
      chk("b2b_cpu", CPU_DOUT, 8'h07);
      chk("b2b_dma", DMA_DOUT, 8'hA2);

      // Reset lands on the return cycle of a CPU read.
      CPU_REQ = 1'b1; CPU_ADDR = 16'h0000;
      step();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0; CPU_REQ = 1'b0;
      step();
      chk("rst_drop_dout", CPU_DOUT, 8'h00);

      // Random traffic with occasional reset.
      new_cpu();
      new_dma();
      for (int i = 0; i < 3000; i++) begin
         RST = ($urandom_range(0, 63) == 0);
         step();
         if (!CPU_REQ || g_cpu) new_cpu();
         if (!DMA_REQ || g_dma) new_dma();
      end
      RST = 1'b0; CPU_REQ = 1'b0; DMA_REQ = 1'b0;
      step();
      step();
      for (int a = 0; a < 8; a++)
         chk("mem_final", tb_rd(16'(a)), ref_rd(16'(a)));

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
